// File: rtl/freq_report_formatter_pkg.sv
`default_nettype none
// ============================================================================
// Module : freq_report_formatter_pkg
// Brief  : ASCII constants, message geometry, FSM encoding and BCD helpers
//          shared by the frequency report formatter.
// Rev    : 1.0
// ============================================================================
package freq_report_formatter_pkg;

  localparam int MSG_LEN = 16;
  localparam int DIGITS  = 10;
  localparam int BCD_W   = 4 * DIGITS;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_EQ    = 8'h3D;
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_F     = 8'h46;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_SEND    = 2'd2;

  // Double-dabble pre-shift correction: every digit >= 5 gets +3.
  function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (r[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = r[4*k +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] status_char(input logic match, input logic too_high,
                                             input logic too_low);
    logic [7:0] c;
    if (match)         c = ASCII_EQ;
    else if (too_high) c = ASCII_PLUS;
    else if (too_low)  c = ASCII_MINUS;
    else               c = ASCII_QMARK;
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/freq_report_formatter_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module : bin2bcd_seq
// Brief  : Sequential double-dabble, one shift per clock, DATA_W steps,
//          10-digit BCD result with a one-cycle done pulse.
// Rev    : 1.0
// ============================================================================
module bin2bcd_seq
  import freq_report_formatter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] bin,
  output logic              done,
  output logic [BCD_W-1:0]  bcd
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] r_shift;
  logic [BCD_W-1:0]  r_bcd;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [BCD_W-1:0]  w_adj;

  assign w_adj = bcd_add3(r_bcd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_busy) begin
        r_bcd   <= {w_adj[BCD_W-2:0], r_shift[DATA_W-1]};
        r_shift <= r_shift << 1;
        if (r_cnt == CNT_W'(DATA_W - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else if (start) begin
        r_shift <= bin;
        r_bcd   <= '0;
        r_cnt   <= '0;
        r_busy  <= 1'b1;
      end
    end
  end

  assign done = r_done;
  assign bcd  = r_bcd;

endmodule
`default_nettype wire

// File: rtl/freq_report_formatter.sv
`default_nettype none
// ============================================================================
// Module : freq_report_formatter
// Brief  : Formats one frequency sample plus comparator status as the ASCII
//          line "F=dddddddddd s\r\n" and streams it to uart_tx.
// Rev    : 1.0
// ============================================================================
module freq_report_formatter
  import freq_report_formatter_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter bit SUPPRESS_ZEROS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] measured_freq,
  input  logic              sample_valid,
  input  logic              freq_match,
  input  logic              freq_too_high,
  input  logic              freq_too_low,
  output logic [7:0]        tx_data,
  output logic              tx_data_valid,
  input  logic              tx_data_ready,
  output logic              busy,
  output logic              sample_dropped
);

  logic [1:0]       r_state;
  logic [7:0]       r_status;
  logic [3:0]       r_idx;
  logic             r_valid;
  logic             r_dropped;

  logic             w_start;
  logic             w_conv_done;
  logic [BCD_W-1:0] w_bcd;
  logic [7:0]       w_byte;
  logic [DIGITS-1:0] w_zero_digit;
  logic [DIGITS-1:1] w_lead_zero;
  logic [7:0]       w_digit_char [DIGITS];

  assign w_start = (r_state == ST_IDLE) && sample_valid;

  bin2bcd_seq #(
    .DATA_W (DATA_W)
  ) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_start),
    .bin   (measured_freq),
    .done  (w_conv_done),
    .bcd   (w_bcd)
  );

  // A digit is blanked only while it and every digit above it are zero.
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    assign w_zero_digit[k] = (w_bcd[4*k +: 4] == 4'd0);
    if (k == DIGITS - 1) begin : g_top
      assign w_lead_zero[k] = w_zero_digit[k];
    end else if (k > 0) begin : g_mid
      assign w_lead_zero[k] = w_lead_zero[k+1] & w_zero_digit[k];
    end
    if (k == 0) begin : g_units
      assign w_digit_char[k] = ASCII_ZERO | {4'd0, w_bcd[4*k +: 4]};
    end else begin : g_upper
      assign w_digit_char[k] = (SUPPRESS_ZEROS && w_lead_zero[k]) ? ASCII_SPACE
                             : (ASCII_ZERO | {4'd0, w_bcd[4*k +: 4]});
    end
  end

  always_comb begin
    w_byte = ASCII_SPACE;
    case (r_idx)
      4'd0:    w_byte = ASCII_F;
      4'd1:    w_byte = ASCII_EQ;
      4'd12:   w_byte = ASCII_SPACE;
      4'd13:   w_byte = r_status;
      4'd14:   w_byte = ASCII_CR;
      4'd15:   w_byte = ASCII_LF;
      default: w_byte = w_digit_char[4'd11 - r_idx];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_status  <= 8'h00;
      r_idx     <= 4'd0;
      r_valid   <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      r_dropped <= sample_valid && (r_state != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (sample_valid) begin
            r_status <= status_char(freq_match, freq_too_high, freq_too_low);
            r_idx    <= 4'd0;
            r_state  <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          if (w_conv_done) begin
            r_valid <= 1'b1;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tx_data_ready) begin
            if (r_idx == 4'(MSG_LEN - 1)) begin
              r_valid <= 1'b0;
              r_idx   <= 4'd0;
              r_state <= ST_IDLE;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tx_data        = r_valid ? w_byte : 8'h00;
  assign tx_data_valid  = r_valid;
  assign busy           = (r_state != ST_IDLE);
  assign sample_dropped = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_freq_report_formatter.sv
`default_nettype none
// ============================================================================
// Module : tb_freq_report_formatter
// Brief  : Scoreboard bench for freq_report_formatter, with blanking on and off.
// Rev    : 1.0
// ============================================================================
module tb_freq_report_formatter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] measured_freq = '0;
  logic        sample_valid = 1'b0;
  logic        freq_match = 1'b0;
  logic        freq_too_high = 1'b0;
  logic        freq_too_low = 1'b0;
  logic        tx_data_ready = 1'b1;

  logic [7:0]  tx_data_s, tx_data_n;
  logic        valid_s, valid_n, busy_s, busy_n, drop_s, drop_n;

  int vectors = 0;
  int miscompares = 0;
  int acc_cnt = 0;
  int cyc = 0;
  int t_first = 0;
  int t_last = 0;
  logic [7:0] q_s[$];
  logic [7:0] q_n[$];
  logic [7:0] exp_s, exp_n;

  freq_report_formatter #(.DATA_W(32), .SUPPRESS_ZEROS(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .measured_freq(measured_freq), .sample_valid(sample_valid),
    .freq_match(freq_match), .freq_too_high(freq_too_high), .freq_too_low(freq_too_low),
    .tx_data(tx_data_s), .tx_data_valid(valid_s), .tx_data_ready(tx_data_ready),
    .busy(busy_s), .sample_dropped(drop_s)
  );

  freq_report_formatter #(.DATA_W(32), .SUPPRESS_ZEROS(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .measured_freq(measured_freq), .sample_valid(sample_valid),
    .freq_match(freq_match), .freq_too_high(freq_too_high), .freq_too_low(freq_too_low),
    .tx_data(tx_data_n), .tx_data_valid(valid_n), .tx_data_ready(tx_data_ready),
    .busy(busy_n), .sample_dropped(drop_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bytes that will be accepted on the coming posedge are scored here.
  always @(negedge clk) begin
    if (rst_n && valid_s && tx_data_ready) begin
      vectors++;
      if (q_s.size() == 0) begin
        miscompares++;
        $display("FAIL byte_blank: got %h, no byte expected", tx_data_s);
      end else begin
        exp_s = q_s.pop_front();
        if (tx_data_s !== exp_s) begin
          miscompares++;
          $display("FAIL byte_blank[%0d]: got %h, expected %h", acc_cnt, tx_data_s, exp_s);
        end
      end
      if (acc_cnt == 0) t_first = cyc;
      if (acc_cnt == 15) t_last = cyc;
      acc_cnt++;
    end
    if (rst_n && valid_n && tx_data_ready) begin
      vectors++;
      if (q_n.size() == 0) begin
        miscompares++;
        $display("FAIL byte_full: got %h, no byte expected", tx_data_n);
      end else begin
        exp_n = q_n.pop_front();
        if (tx_data_n !== exp_n) begin
          miscompares++;
          $display("FAIL byte_full: got %h, expected %h", tx_data_n, exp_n);
        end
      end
    end
  end

  task automatic push_line(input logic [31:0] v, input logic m, input logic h, input logic l);
    logic [3:0]  d[10];
    logic [31:0] x;
    logic [7:0]  st;
    bit          lead;
    x = v;
    for (int i = 0; i < 10; i++) begin
      d[i] = 4'(x % 10);
      x = x / 10;
    end
    st = m ? 8'h3D : h ? 8'h2B : l ? 8'h2D : 8'h3F;
    q_s.push_back(8'h46); q_s.push_back(8'h3D);
    q_n.push_back(8'h46); q_n.push_back(8'h3D);
    lead = 1'b1;
    for (int k = 9; k >= 0; k--) begin
      q_n.push_back(8'h30 + {4'h0, d[k]});
      if (lead && d[k] == 4'd0 && k != 0) q_s.push_back(8'h20);
      else begin
        lead = 1'b0;
        q_s.push_back(8'h30 + {4'h0, d[k]});
      end
    end
    q_s.push_back(8'h20); q_s.push_back(st); q_s.push_back(8'h0D); q_s.push_back(8'h0A);
    q_n.push_back(8'h20); q_n.push_back(st); q_n.push_back(8'h0D); q_n.push_back(8'h0A);
  endtask

  // Entered and left at posedge+1; returns just after the capture edge.
  task automatic send(input logic [31:0] v, input logic m, input logic h, input logic l);
    acc_cnt = 0;
    push_line(v, m, h, l);
    measured_freq = v;
    freq_match = m; freq_too_high = h; freq_too_low = l;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    measured_freq = $urandom;
    freq_match = ~m; freq_too_high = ~h; freq_too_low = ~l;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((busy_s || busy_n || q_s.size() != 0 || q_n.size() != 0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (n >= 3000) begin
      miscompares++;
      $display("FAIL %s_done: busy=%b pending=%0d after %0d cycles, required idle", name,
               busy_s, q_s.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (tx_data_s !== 8'h00) begin miscompares++; $display("FAIL rst_data: got %h, required 00", tx_data_s); end
    vectors++; if (valid_s !== 1'b0 || valid_n !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b/%b, required 0", valid_s, valid_n); end
    vectors++; if (busy_s !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b, required 0", busy_s); end
    vectors++; if (drop_s !== 1'b0) begin miscompares++; $display("FAIL rst_drop: got %b, required 0", drop_s); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    int n = 0;
    bit found = 0;
    tx_data_ready = 1'b1;
    send(32'd54000000, 1'b1, 1'b0, 1'b0);
    vectors++; if (busy_s !== 1'b1) begin miscompares++; $display("FAIL capture_busy: got %b, required 1", busy_s); end
    while (!found && n < 100) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (valid_s) found = 1;
    end
    vectors++; if (n !== 33) begin miscompares++; $display("FAIL latency: got %0d edges, required 33", n); end
    @(posedge clk); #1;
    wait_done("latency");
    vectors++; if (t_last - t_first !== 15) begin miscompares++; $display("FAIL back_to_back: got span %0d, required 15", t_last - t_first); end
  endtask

  task automatic test_values();
    send(32'd0, 1'b0, 1'b0, 1'b0);
    wait_done("zero");
    send(32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1);
    wait_done("max");
    send(32'd7, 1'b0, 1'b0, 1'b1);
    wait_done("one_digit");
  endtask

  task automatic test_stall();
    int n = 0;
    bit stable = 1;
    send(32'd53460000, 1'b0, 1'b0, 1'b1);
    while (acc_cnt < 5 && n < 200) begin @(posedge clk); #1; n++; end
    tx_data_ready = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (q_s.size() == 0 || tx_data_s !== q_s[0] || valid_s !== 1'b1) stable = 0;
    end
    vectors++; if (!stable) begin miscompares++; $display("FAIL stall_hold: got %h valid=%b, required held byte 5", tx_data_s, valid_s); end
    @(posedge clk); #1;
    tx_data_ready = 1'b1;
    wait_done("stall");
    vectors++; if (acc_cnt !== 16) begin miscompares++; $display("FAIL stall_count: got %0d bytes, required 16", acc_cnt); end
  endtask

  task automatic test_drop();
    int n = 0;
    int drops = 0;
    send(32'd12345, 1'b1, 1'b0, 1'b0);
    while (busy_s && n < 3000) begin
      @(posedge clk); #1; n++;
      if (n % 5 == 0 && busy_s) begin
        measured_freq = $urandom;
        freq_match = 1'b0; freq_too_high = 1'b1;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        @(negedge clk);
        vectors++; drops++;
        if (drop_s !== 1'b1) begin miscompares++; $display("FAIL drop_pulse: got %b, required 1", drop_s); end
        @(posedge clk); #1;
        vectors++; if (drop_s !== 1'b0) begin miscompares++; $display("FAIL drop_width: got %b, required 0", drop_s); end
      end
    end
    wait_done("drop");
    vectors++; if (drops < 3) begin miscompares++; $display("FAIL drop_count: got %0d, required >=3", drops); end
    send(32'd987654321, 1'b0, 1'b0, 1'b0);
    wait_done("after_drop");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    send(32'd777, 1'b0, 1'b1, 1'b0);
    while (acc_cnt < 8 && n < 200) begin @(posedge clk); #1; n++; end
    rst_n = 1'b0;
    #1;
    vectors++; if (valid_s !== 1'b0 || tx_data_s !== 8'h00) begin miscompares++; $display("FAIL abort_valid: got %b/%h, required 0/00", valid_s, tx_data_s); end
    vectors++; if (busy_s !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b, required 0", busy_s); end
    q_s.delete();
    q_n.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(32'd1000000, 1'b0, 1'b1, 1'b0);
    wait_done("after_reset");
    vectors++; if (acc_cnt !== 16) begin miscompares++; $display("FAIL after_reset_count: got %0d bytes, required 16", acc_cnt); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_latency();
    test_values();
    test_stall();
    test_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
